// File: rtl/div_16x8_seq.sv
// Sequential 16/8 unsigned restoring divider: one quotient bit per cycle,
// valid/ready handshake on both sides, divide-by-zero and overflow flags.
module div_16x8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] R,
    input  logic [7:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  Q,
    output logic [7:0]  REM,
    output logic        dz,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q;
    logic [7:0]  p_q;      // partial remainder; p < B keeps it within 8 bits
    logic [7:0]  s_q;
    logic [7:0]  b_q;
    logic [2:0]  cnt_q;
    logic [7:0]  q_q;
    logic [7:0]  rem_q;
    logic        dz_q;
    logic        ovf_q;

    logic [8:0]  t;
    logic        qbit;
    logic [7:0]  p_d;
    logic [7:0]  s_d;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
    always_comb begin
        t    = {p_q, s_q[7]};
        qbit = (t >= {1'b0, b_q});
        p_d  = qbit ? 8'(t - {1'b0, b_q}) : t[7:0];
        s_d  = {s_q[6:0], qbit};
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            s_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        b_q <= B;
                        p_q <= R[15:8];
                        s_q <= R[7:0];
                        if (B == 8'd0) begin
                            q_q     <= 8'hFF;
                            rem_q   <= R[7:0];
                            dz_q    <= 1'b1;
                            ovf_q   <= 1'b0;
                            state_q <= DONE;
                        end else if (R[15:8] >= B) begin
                            q_q     <= 8'hFF;
                            rem_q   <= 8'h00;
                            dz_q    <= 1'b0;
                            ovf_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cnt_q   <= '0;
                            dz_q    <= 1'b0;
                            ovf_q   <= 1'b0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    p_q <= p_d;
                    s_q <= s_d;
                    if (cnt_q == 3'd7) begin
                        q_q     <= s_d;
                        rem_q   <= p_d;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Q         = q_q;
    assign REM       = rem_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/div_16x8_seq.md
# div_16x8_seq

Sequential 16-by-8 unsigned restoring divider, the inverse operator of the 8x8 multipliers in this codebase. It takes a 16-bit product-width dividend and an 8-bit divisor and returns an 8-bit quotient and an 8-bit remainder. Quotient bits are produced at one per cycle behind a valid/ready handshake. It also serves as the exact inverse reference in multiplier characterization benches: for B ≠ 0 and any exact R = A·B, it must return Q = A, REM = 0.

## Interface
- No parameters; widths are fixed at 16/8.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands R and B are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- R  input  16  unsigned dividend, sampled on accept.
- B  input  8  unsigned divisor, sampled on accept.
- out_valid  output  1  Q, REM, dz and ovf are valid.
- out_ready  input  1  downstream accepts the result.
- Q  output  8  quotient.
- REM  output  8  remainder.
- dz  output  1  divide-by-zero flag.
- ovf  output  1  quotient does not fit in 8 bits.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - Accept occurs on a rising edge with in_valid & in_ready. On accept, latch B and R.
  - If B == 0: set Q = 8'hFF, REM = R[7:0], dz = 1, ovf = 0. Go to DONE.
  - Else if R[15:8] >= B: set Q = 8'hFF, REM = 8'h00, dz = 0, ovf = 1. Go to DONE.
  - Otherwise: load the 9-bit partial remainder p = {1'b0, R[15:8]} and the shift register s = R[7:0]. Clear the step counter (3 bits) and both flags. Go to CALC.
- CALC, once per cycle:
  - t = {p[7:0], s[7]}, 9 bits.
  - If t >= {1'b0, B}: p = t − B and qbit = 1. Else p = t and qbit = 0.
  - s = {s[6:0], qbit}. Quotient bits are shifted in MSB-first, replacing dividend bits.
  - When the counter reaches 7: set Q = the final s, REM = p[7:0], and go to DONE. Otherwise increment the counter.
  - Invariant: p < B ≤ 255, so t ≤ 510 fits in 9 bits and REM always fits in 8 bits.
- DONE:
  - out_valid = 1. Q, REM, dz and ovf are held stable while out_valid is high and out_ready is low.
  - On an edge with out_ready = 1, go to IDLE. out_valid drops in the next cycle.
- in_ready is 0 in CALC and DONE. A new operand is never accepted in the same edge as a result handoff.
- Reset, from any state including mid-CALC:
  - Go to IDLE.
  - in_ready = 1 after the reset edge.
  - out_valid = 0, Q = 0, REM = 0, dz = 0, ovf = 0.
  - Clear all internal registers. Any in-flight operation is discarded with no output.
  - in_valid asserted during reset is ignored.

## Timing
- Normal divide:
  - Accept at edge t0.
  - CALC edges are t0+1 through t0+8.
  - out_valid is high from the cycle after t0+8.
  - Latency is 9 edges from accept to result visible.
- dz/ovf case: out_valid is high from the cycle after t0, i.e. latency 1.
- Handoff at edge tH with out_ready high: in_ready is high after tH, and the earliest next accept is edge tH+1.
- Maximum throughput is one divide per 10 cycles when out_ready is held high.
- Outputs are registered; there is no combinational path from inputs to outputs. in_ready is a decode of the state register only.
- Q and REM change only on the CALC→DONE edge, the IDLE→DONE edge, or reset.

## Test plan
- Basic divide: R = 16'd1000, B = 8'd7 → after 9 edges out_valid = 1 with Q = 142, REM = 6, dz = 0, ovf = 0. Also R = 16'h07FF, B = 8 → Q = 255, REM = 7, which is the boundary just below overflow.
- Exceptions:
  - R = 16'h0800, B = 8 → ovf = 1, Q = 8'hFF, REM = 0, out_valid one cycle after accept.
  - R = 16'h1234, B = 0 → dz = 1, Q = 8'hFF, REM = 8'h34.
  - R = 0, B = 0 → dz = 1; dz takes priority over ovf.
- Backpressure:
  - Hold out_ready low for 5 cycles in DONE → out_valid stays high, Q and REM are stable, in_ready stays 0, and a second in_valid pulse is not accepted.
  - Release out_ready → IDLE, and the next operand is accepted one edge later.
- Reset mid-operation:
  - Assert rst at the 4th CALC edge of 1000/7 → the next cycle shows IDLE, in_ready = 1, out_valid = 0, all outputs 0.
  - Then 65025/255 → Q = 255, REM = 0.
- Exhaustive inverse check:
  - For all A in 0..255 and B in 1..255, apply R = A·B exact → Q = A, REM = 0, ovf = 0.
  - Also R = A·B + (B−1) → Q = A, REM = B−1.
  - Compare each result against a behavioral reference, with out_ready randomly toggled.
